// File: rtl/fetch_stage_pkg.sv
// Shared word width, default reset vector and fetch FSM encodings for the
// instruction-fetch stage.
package fetch_stage_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [WORD_W-1:0] PC_STEP          = 32'd4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        MISS  = 2'd1,
        STALL = 2'd2
    } fetch_state_e;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] a);
        return a & ~(WORD_W'(3));
    endfunction

endpackage

// File: rtl/fetch_pc.sv
// Program counter register and next-pc selection: redirect beats sequential
// advance, otherwise the pc holds so the cache sees a stable address.
module fetch_pc
    import fetch_stage_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_redirect_valid,
    input  logic [WORD_W-1:0] i_redirect_pc,
    input  logic              i_advance,
    output logic [WORD_W-1:0] o_pc,
    output logic [WORD_W-1:0] o_pc_next
);

    logic [WORD_W-1:0] r_pc;
    logic [WORD_W-1:0] w_pc_next;

    always_comb begin
        w_pc_next = r_pc;
        if (i_redirect_valid) begin
            w_pc_next = word_align(i_redirect_pc);
        end else if (i_advance) begin
            w_pc_next = r_pc + PC_STEP;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc      = r_pc;
    assign o_pc_next = w_pc_next;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: drives the cache address, rides out misses,
// and hands fetched words to decode through a valid/ready IF/ID slot.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
)
(
    input  logic              clk,
    input  logic              reset,
    output logic [WORD_W-1:0] cache_addr,
    input  logic [WORD_W-1:0] cache_data,
    input  logic              cache_ready,
    input  logic              redirect_valid,
    input  logic [WORD_W-1:0] redirect_pc,
    input  logic              id_ready,
    output logic              id_valid,
    output logic [WORD_W-1:0] id_inst,
    output logic [WORD_W-1:0] id_pc,
    output logic [WORD_W-1:0] id_pc4,
    output logic [WORD_W-1:0] miss_cycles
);

    fetch_state_e      r_state;
    fetch_state_e      w_state_nxt;
    logic              r_id_valid;
    logic [WORD_W-1:0] r_id_inst;
    logic [WORD_W-1:0] r_id_pc;
    logic [WORD_W-1:0] r_miss_cycles;

    logic              w_slot_free;
    logic              w_xfer;
    logic              w_load;
    logic [WORD_W-1:0] w_pc;
    logic [WORD_W-1:0] w_pc_next;

    fetch_pc #(
        .RESET_PC (RESET_PC)
    ) u_fetch_pc (
        .clk              (clk),
        .reset            (reset),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .i_advance        (w_load),
        .o_pc             (w_pc),
        .o_pc_next        (w_pc_next)
    );

    // A hit is only consumed when the slot can take it and no redirect
    // is discarding this cycle's fetch.
    always_comb begin
        w_state_nxt = r_state;
        w_slot_free = !r_id_valid || id_ready;
        w_xfer      = r_id_valid && id_ready;
        w_load      = 1'b0;

        if (redirect_valid) begin
            w_state_nxt = FETCH;
        end else if (!cache_ready) begin
            w_state_nxt = MISS;
        end else if (w_slot_free) begin
            w_load      = 1'b1;
            w_state_nxt = FETCH;
        end else begin
            w_state_nxt = STALL;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // IF/ID slot: inst/pc hold their last values whenever nothing is loaded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_id_valid <= 1'b0;
            r_id_inst  <= '0;
            r_id_pc    <= '0;
        end else if (redirect_valid) begin
            r_id_valid <= 1'b0;
        end else if (w_load) begin
            r_id_valid <= 1'b1;
            r_id_inst  <= cache_data;
            r_id_pc    <= w_pc;
        end else if (w_xfer) begin
            r_id_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_miss_cycles <= '0;
        end else if (r_state == MISS) begin
            r_miss_cycles <= r_miss_cycles + 1'b1;
        end
    end

    assign cache_addr  = w_pc;
    assign id_valid    = r_id_valid;
    assign id_inst     = r_id_inst;
    assign id_pc       = r_id_pc;
    assign id_pc4      = r_id_pc + PC_STEP;
    assign miss_cycles = r_miss_cycles;

endmodule
